// File: rtl/detector_botoes_multi.sv
`default_nettype none
// ============================================================================
// Module      : detector_botoes_multi
// Description : Multi-channel push-button conditioner. Each channel has its
//               own 2-flop synchroniser, stable-time debouncer, press/release
//               edge pulses, long-press pulse and optional auto-repeat pulses.
//               All channels are independent and share only clk/rst.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-high reset
//               botoes_in    - raw asynchronous button levels
//               estado       - debounced level per channel (1 = pressed)
//               pulso_sobe   - one-cycle pulse on debounced press
//               pulso_desce  - one-cycle pulse on debounced release
//               pulso_longo  - one-cycle pulse after CICLOS_LONGO held cycles
//               pulso_repete - periodic one-cycle pulses after long press
// Revision    : 1.0 - initial release
// ============================================================================
module detector_botoes_multi #(
  parameter int N_BOTOES        = 4,
  parameter int CICLOS_DEBOUNCE = 500000,
  parameter int CICLOS_LONGO    = 50000000,
  parameter int CICLOS_REPETE   = 10000000,
  parameter int HABILITA_REPETE = 1,
  parameter int ATIVO_BAIXO     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] botoes_in,
  output logic [N_BOTOES-1:0] estado,
  output logic [N_BOTOES-1:0] pulso_sobe,
  output logic [N_BOTOES-1:0] pulso_desce,
  output logic [N_BOTOES-1:0] pulso_longo,
  output logic [N_BOTOES-1:0] pulso_repete
);

  localparam int W_DEB  = $clog2(CICLOS_DEBOUNCE + 1);
  localparam int W_HOLD = $clog2(CICLOS_LONGO + 1);
  localparam int W_REP  = $clog2(CICLOS_REPETE + 1);

  localparam logic [W_DEB-1:0]  DEB_ULTIMO = W_DEB'(CICLOS_DEBOUNCE - 1);
  localparam logic [W_HOLD-1:0] HOLD_FIM   = W_HOLD'(CICLOS_LONGO);
  localparam logic [W_HOLD-1:0] HOLD_PRE   = W_HOLD'(CICLOS_LONGO - 1);
  localparam logic [W_REP-1:0]  REP_ULTIMO = W_REP'(CICLOS_REPETE - 1);
  localparam logic              INVERTE    = (ATIVO_BAIXO != 0);

  logic [N_BOTOES-1:0] entrada;
  logic [N_BOTOES-1:0] sync1;
  logic [N_BOTOES-1:0] sync2;
  logic [N_BOTOES-1:0] estado_anterior;

  // Inversion happens before the synchroniser so that everything downstream,
  // including the reset level, is in "1 = pressed" terms.
  assign entrada = botoes_in ^ {N_BOTOES{INVERTE}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= entrada;
      sync2 <= sync1;
    end
  end

  // Edge pulses compare the debounced level with its one-cycle-old copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_anterior <= '0;
      pulso_sobe      <= '0;
      pulso_desce     <= '0;
    end else begin
      estado_anterior <= estado;
      pulso_sobe      <= estado & ~estado_anterior;
      pulso_desce     <= ~estado & estado_anterior;
    end
  end

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    logic [W_DEB-1:0]  cnt_deb;
    logic [W_HOLD-1:0] cnt_hold;
    logic              estado_q;
    logic              longo_q;

    // Counter only advances while the synchronised level disagrees with the
    // accepted level; any agreeing cycle discards all accumulated credit.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_deb  <= '0;
        estado_q <= 1'b0;
      end else if (sync2[i] == estado_q) begin
        cnt_deb <= '0;
      end else if (cnt_deb == DEB_ULTIMO) begin
        estado_q <= sync2[i];
        cnt_deb  <= '0;
      end else begin
        cnt_deb <= cnt_deb + 1'b1;
      end
    end

    // Hold timer saturates at the long-press point; the pulse is issued on
    // the single edge where it steps onto that value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_hold <= '0;
        longo_q  <= 1'b0;
      end else begin
        longo_q <= 1'b0;
        if (!estado_q) begin
          cnt_hold <= '0;
        end else if (cnt_hold != HOLD_FIM) begin
          cnt_hold <= cnt_hold + 1'b1;
          longo_q  <= (cnt_hold == HOLD_PRE);
        end
      end
    end

    assign estado[i]      = estado_q;
    assign pulso_longo[i] = longo_q;

    if (HABILITA_REPETE != 0) begin : g_repete
      logic [W_REP-1:0] cnt_rep;
      logic             repete_q;

      // Runs only once the hold timer sits at the long point, so the first
      // repeat lands a full period after pulso_longo and never on it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_rep  <= '0;
          repete_q <= 1'b0;
        end else if (!estado_q || (cnt_hold != HOLD_FIM)) begin
          cnt_rep  <= '0;
          repete_q <= 1'b0;
        end else if (cnt_rep == REP_ULTIMO) begin
          cnt_rep  <= '0;
          repete_q <= 1'b1;
        end else begin
          cnt_rep  <= cnt_rep + 1'b1;
          repete_q <= 1'b0;
        end
      end

      assign pulso_repete[i] = repete_q;
    end else begin : g_sem_repete
      assign pulso_repete[i] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_detector_botoes_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_detector_botoes_multi
// Description : Self-checking bench for detector_botoes_multi. Two instances
//               (active-high and active-low inputs) are driven with directed
//               and random button activity and compared every cycle against
//               a run-length / elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_botoes_multi;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int CL = 20;
  localparam int CR = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] bot_a, bot_b;
  logic [N-1:0] est_a, sobe_a, desce_a, longo_a, rep_a;
  logic [N-1:0] est_b, sobe_b, desce_b, longo_b, rep_b;

  always #5 clk = ~clk;

  detector_botoes_multi #(
    .N_BOTOES(N), .CICLOS_DEBOUNCE(CD), .CICLOS_LONGO(CL),
    .CICLOS_REPETE(CR), .HABILITA_REPETE(1), .ATIVO_BAIXO(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .botoes_in(bot_a), .estado(est_a),
    .pulso_sobe(sobe_a), .pulso_desce(desce_a), .pulso_longo(longo_a),
    .pulso_repete(rep_a)
  );

  detector_botoes_multi #(
    .N_BOTOES(N), .CICLOS_DEBOUNCE(CD), .CICLOS_LONGO(CL),
    .CICLOS_REPETE(CR), .HABILITA_REPETE(1), .ATIVO_BAIXO(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .botoes_in(bot_b), .estado(est_b),
    .pulso_sobe(sobe_b), .pulso_desce(desce_b), .pulso_longo(longo_b),
    .pulso_repete(rep_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The accepted level follows the input delayed by two samples once that
  // delayed stream has held a new value for CD consecutive samples. Long and
  // repeat pulses are derived from the elapsed time since the level rose.
  longint   edge_n;
  bit       m_d1[2][N], m_d2[2][N], m_seen[2][N], m_est[2][N], m_ant[2][N];
  int       m_run[2][N];
  longint   m_rise[2][N];
  logic [N-1:0] e_est[2], e_sobe[2], e_desce[2], e_longo[2], e_rep[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        m_d1[d][i] = 0; m_d2[d][i] = 0; m_seen[d][i] = 0;
        m_est[d][i] = 0; m_ant[d][i] = 0; m_run[d][i] = 0; m_rise[d][i] = 0;
      end
      e_est[d] = '0; e_sobe[d] = '0; e_desce[d] = '0; e_longo[d] = '0; e_rep[d] = '0;
    end
  endtask

  task automatic model_step();
    bit raw, cur, seen, pre, ant, nxt;
    longint age;
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        raw  = (d == 0) ? bot_a[i] : bot_b[i];
        cur  = raw ^ (d == 1);
        seen = m_d2[d][i];
        pre  = m_est[d][i];
        ant  = m_ant[d][i];
        if (seen == m_seen[d][i]) m_run[d][i]++;
        else m_run[d][i] = 1;
        m_seen[d][i] = seen;
        nxt = pre;
        if (seen != pre && m_run[d][i] >= CD) nxt = seen;
        age = edge_n - m_rise[d][i];
        e_sobe[d][i]  = pre & ~ant;
        e_desce[d][i] = ~pre & ant;
        e_longo[d][i] = pre && (age == CL);
        e_rep[d][i]   = pre && (age > CL) && (((age - CL) % CR) == 0);
        if (nxt && !pre) m_rise[d][i] = edge_n;
        m_d2[d][i]  = m_d1[d][i];
        m_d1[d][i]  = cur;
        m_ant[d][i] = pre;
        m_est[d][i] = nxt;
        e_est[d][i] = nxt;
      end
    end
  endtask

  task automatic check_all();
    verifica("estado_a", est_a,   e_est[0]);
    verifica("sobe_a",   sobe_a,  e_sobe[0]);
    verifica("desce_a",  desce_a, e_desce[0]);
    verifica("longo_a",  longo_a, e_longo[0]);
    verifica("repete_a", rep_a,   e_rep[0]);
    verifica("estado_b", est_b,   e_est[1]);
    verifica("sobe_b",   sobe_b,  e_sobe[1]);
    verifica("desce_b",  desce_b, e_desce[1]);
    verifica("longo_b",  longo_b, e_longo[1]);
    verifica("repete_b", rep_b,   e_rep[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  int cnt, first_longo, first_rep, n_sobe, n_desce, n_longo, rep_after;
  bit desce_seen;
  int rem[2][N];

  initial begin
    edge_n = 0;
    rst    = 1'b1;
    bot_a  = '0;
    bot_b  = '1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Scenario 1: clean press on channel 0, latency and single press pulse.
    bot_a[0] = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (!est_a[0] && cnt < 20);
    verifica("lat_estado_a0", cnt, 6);
    tick();
    verifica("sobe_a0_once", sobe_a, 4'b0001);
    tick();
    verifica("sobe_a0_gone", sobe_a, 4'b0000);
    bot_a[0] = 1'b0;
    repeat (10) tick();

    // Scenario 2: 3-cycle glitches on channel 1 never qualify.
    for (int g = 0; g < 5; g++) begin
      bot_a[1] = 1'b1; repeat (3) tick();
      bot_a[1] = 1'b0; repeat (3) tick();
    end
    repeat (6) tick();
    verifica("glitch_estado_a1", est_a[1], 1'b0);

    // Scenario 3: long hold on channel 2 with auto-repeat, then release.
    bot_a[2] = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (!est_a[2] && cnt < 20);
    verifica("rise_a2", est_a[2], 1'b1);
    first_longo = -1; first_rep = -1; n_longo = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (longo_a[2]) begin n_longo++; if (first_longo < 0) first_longo = k; end
      if (rep_a[2] && first_rep < 0) first_rep = k;
    end
    verifica("longo_a2_offset", first_longo, CL);
    verifica("longo_a2_count", n_longo, 1);
    verifica("repete_a2_offset", first_rep, CL + CR);
    bot_a[2] = 1'b0;
    n_desce = 0; rep_after = 0; desce_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (desce_a[2]) begin n_desce++; desce_seen = 1; end
      if (desce_seen && rep_a[2]) rep_after++;
    end
    verifica("desce_a2_count", n_desce, 1);
    verifica("repete_after_release", rep_after, 0);

    // Scenario 4: short press on channel 3, no long pulse.
    bot_a[3] = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (!est_a[3] && cnt < 20);
    n_sobe = 0; n_desce = 0; n_longo = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) bot_a[3] = 1'b0;
      tick();
      n_sobe  += int'(sobe_a[3]);
      n_desce += int'(desce_a[3]);
      n_longo += int'(longo_a[3]);
    end
    verifica("short_sobe_a3", n_sobe, 1);
    verifica("short_desce_a3", n_desce, 1);
    verifica("short_longo_a3", n_longo, 0);

    // Scenario 5: asynchronous reset in the middle of a hold.
    bot_a[0] = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (!est_a[0] && cnt < 20);
    repeat (12) tick();
    rst = 1'b1;
    model_reset();
    #1;
    verifica("async_rst_a", {est_a, sobe_a, desce_a, longo_a, rep_a}, 20'h0);
    verifica("async_rst_b", {est_b, sobe_b, desce_b, longo_b, rep_b}, 20'h0);
    repeat (2) tick();
    rst = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!sobe_a[0] && cnt < 20);
    verifica("resobe_a0_latency", cnt, CD + 3);
    cnt = 1;
    do begin tick(); cnt++; end while (!longo_a[0] && cnt < 40);
    verifica("relongo_a0_offset", cnt, CL);
    bot_a[0] = 1'b0;
    repeat (10) tick();

    // Scenario 6: active-low instance, latency and simultaneous channels.
    bot_b[0] = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!est_b[0] && cnt < 20);
    verifica("lat_estado_b0", cnt, 6);
    tick();
    verifica("sobe_b0_once", sobe_b, 4'b0001);
    bot_b[0] = 1'b1;
    repeat (15) tick();
    bot_b[0] = 1'b0;
    bot_b[2] = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (sobe_b == '0 && cnt < 20);
    verifica("sobe_b_simult", sobe_b, 4'b0101);
    bot_b = '1;
    repeat (10) tick();

    // Random phase: independent random press/release durations per channel.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++)
        rem[d][i] = $urandom_range(1, 40);
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (rem[d][i] == 0) begin
            if (d == 0) bot_a[i] = ~bot_a[i];
            else bot_b[i] = ~bot_b[i];
            rem[d][i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                     : $urandom_range(6, 45);
          end else begin
            rem[d][i]--;
          end
        end
      end
      tick();
    end

    bot_a = '0;
    bot_b = '1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
